// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, widths and the registered output bundle
// used by the scan generator and by sprite blocks for their screen-window bounds.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int   CLK_DIV     = 2;
  localparam logic SYNC_ACTIVE = 1'b0;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int ROW_W = 9;
  localparam int COL_W = 10;
  localparam int CNT_W = 10;
  localparam int DIV_W = 2;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic             pix_en;
    logic             frame_tick;
  } scan_out_t;

  function automatic logic sync_level(input logic asserted, input logic active_level);
    return asserted ? active_level : ~active_level;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, plus active-window, sync-window and
// saturated-position decode. Used once for pixels and once for lines.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE,
  parameter int FP     = H_FP,
  parameter int SYNC   = H_SYNC,
  parameter int BP     = H_BP,
  parameter int POS_W  = COL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             active,
  output logic             in_sync,
  output logic [POS_W-1:0] pos
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [POS_W-1:0] POS_MAX    = POS_W'(ACTIVE - 1);

  // NOTE: state registers use non-blocking assignments and reset asynchronously, so
  // every flop sees pre-edge values of its neighbours regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

  assign wrap    = en && (cnt == LAST);
  assign active  = (cnt < ACTIVE_END);
  assign in_sync = (cnt >= SYNC_FIRST) && (cnt <= SYNC_LAST);

  // Consumers index ROMs with pos, so it parks on the last visible index in blanking.
  assign pos = active ? cnt[POS_W-1:0] : POS_MAX;

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: pixel divider, h/v counters and a registered output
// stage giving row/col, syncs, video_on, pix_en and a once-per-frame tick.
module vga_scan_gen #(
  parameter int   H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int   H_FP        = vga_pkg::H_FP,
  parameter int   H_SYNC      = vga_pkg::H_SYNC,
  parameter int   H_BP        = vga_pkg::H_BP,
  parameter int   V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int   V_FP        = vga_pkg::V_FP,
  parameter int   V_SYNC      = vga_pkg::V_SYNC,
  parameter int   V_BP        = vga_pkg::V_BP,
  parameter int   CLK_DIV     = vga_pkg::CLK_DIV,
  parameter logic SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [vga_pkg::ROW_W-1:0] row,
  output logic [vga_pkg::COL_W-1:0] col,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      video_on,
  output logic                      pix_en,
  output logic                      frame_tick
);

  localparam int DIV_W = vga_pkg::DIV_W;
  localparam int ROW_W = vga_pkg::ROW_W;
  localparam int COL_W = vga_pkg::COL_W;
  localparam int CNT_W = vga_pkg::CNT_W;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam vga_pkg::scan_out_t OUT_RST = '{
    row:        '0,
    col:        '0,
    hsync:      ~SYNC_ACTIVE,
    vsync:      ~SYNC_ACTIVE,
    video_on:   1'b0,
    pix_en:     1'b0,
    frame_tick: 1'b0
  };

  logic [DIV_W-1:0] div;
  logic             adv;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, h_active, h_in_sync;
  logic             v_wrap, v_active, v_in_sync;
  logic [COL_W-1:0] h_pos;
  logic [ROW_W-1:0] v_pos;
  logic             wrapped;
  vga_pkg::scan_out_t out_d, out_q;

  assign adv = (div == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else begin
      div <= adv ? '0 : div + DIV_W'(1);
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POS_W  (COL_W)
  ) u_h (
    .clk     (clk),
    .rst     (reset),
    .en      (adv),
    .cnt     (h_cnt),
    .wrap    (h_wrap),
    .active  (h_active),
    .in_sync (h_in_sync),
    .pos     (h_pos)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POS_W  (ROW_W)
  ) u_v (
    .clk     (clk),
    .rst     (reset),
    .en      (h_wrap),
    .cnt     (v_cnt),
    .wrap    (v_wrap),
    .active  (v_active),
    .in_sync (v_in_sync),
    .pos     (v_pos)
  );

  // Set on the edge the counters wrap to (0,0); the output stage shows that position
  // one clk later, so the flag lines frame_tick up with that pix_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrapped <= 1'b0;
    end else begin
      wrapped <= v_wrap;
    end
  end

  always_comb begin
    out_d            = OUT_RST;
    out_d.row        = v_pos;
    out_d.col        = h_pos;
    out_d.hsync      = vga_pkg::sync_level(h_in_sync, SYNC_ACTIVE);
    out_d.vsync      = vga_pkg::sync_level(v_in_sync, SYNC_ACTIVE);
    out_d.video_on   = h_active && v_active;
    out_d.pix_en     = (div == '0);
    out_d.frame_tick = wrapped;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= OUT_RST;
    end else begin
      out_q <= out_d;
    end
  end

  assign row        = out_q.row;
  assign col        = out_q.col;
  assign hsync      = out_q.hsync;
  assign vsync      = out_q.vsync;
  assign video_on   = out_q.video_on;
  assign pix_en     = out_q.pix_en;
  assign frame_tick = out_q.frame_tick;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a default-timing instance plus two small-raster instances
// (CLK_DIV=2 active-low syncs, CLK_DIV=1 active-high syncs) checked every clk.
module tb_vga_scan_gen;

  // Small raster: 8+2+3+2 = 15 pixels per line, 4+1+2+1 = 8 lines per frame.
  localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 2;
  localparam int SV_A = 4, SV_F = 1, SV_S = 2, SV_B = 1;

  logic clk = 1'b0;
  logic rst;

  logic [8:0] row_a, row_b, row_c;
  logic [9:0] col_a, col_b, col_c;
  logic hsync_a, vsync_a, video_on_a, pix_en_a, frame_tick_a;
  logic hsync_b, vsync_b, video_on_b, pix_en_b, frame_tick_b;
  logic hsync_c, vsync_c, video_on_c, pix_en_c, frame_tick_c;

  int n_vec = 0;
  int n_bad = 0;
  int k = 0;

  int c_hs_low, c_hs_first, c_vo, c_pe, c_max_col;
  int a_vs_low, a_max_col, a_max_row, a_ticks, a_last;
  int b_pe, b_hs_hi, b_ticks, b_last;

  always #5 clk = ~clk;

  vga_scan_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .CLK_DIV(2), .SYNC_ACTIVE(1'b0)
  ) dut_a (
    .clk(clk), .reset(rst), .row(row_a), .col(col_a), .hsync(hsync_a),
    .vsync(vsync_a), .video_on(video_on_a), .pix_en(pix_en_a), .frame_tick(frame_tick_a)
  );

  vga_scan_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .CLK_DIV(1), .SYNC_ACTIVE(1'b1)
  ) dut_b (
    .clk(clk), .reset(rst), .row(row_b), .col(col_b), .hsync(hsync_b),
    .vsync(vsync_b), .video_on(video_on_b), .pix_en(pix_en_b), .frame_tick(frame_tick_b)
  );

  vga_scan_gen dut_c (
    .clk(clk), .reset(rst), .row(row_c), .col(col_c), .hsync(hsync_c),
    .vsync(vsync_c), .video_on(video_on_c), .pix_en(pix_en_c), .frame_tick(frame_tick_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outputs at the k-th clk edge after reset release, from position arithmetic.
  function automatic logic [23:0] model(input int kk, input int ha, input int hf, input int hs,
                                         input int hb, input int va, input int vf, input int vs,
                                         input int vb, input int dv, input logic sa);
    int ht, vt, p, ph, h, v, r, c;
    logic hsy, vsy, vo, pe, ft;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    p   = (kk - 1) / dv;
    ph  = (kk - 1) % dv;
    h   = p % ht;
    v   = (p / ht) % vt;
    r   = (v < va) ? v : va - 1;
    c   = (h < ha) ? h : ha - 1;
    hsy = (h >= ha + hf && h < ha + hf + hs) ? sa : ~sa;
    vsy = (v >= va + vf && v < va + vf + vs) ? sa : ~sa;
    vo  = (h < ha) && (v < va);
    pe  = (ph == 0);
    ft  = (ph == 0) && (p > 0) && (p % (ht * vt) == 0);
    return {9'(r), 10'(c), hsy, vsy, vo, pe, ft};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_a"}, {row_a, col_a, hsync_a, vsync_a, video_on_a, pix_en_a, frame_tick_a}, 32'h18);
    check({tag, "_b"}, {row_b, col_b, hsync_b, vsync_b, video_on_b, pix_en_b, frame_tick_b}, 32'h00);
    check({tag, "_c"}, {row_c, col_c, hsync_c, vsync_c, video_on_c, pix_en_c, frame_tick_c}, 32'h18);
  endtask

  task automatic clear_stats();
    c_hs_low = 0; c_hs_first = 0; c_vo = 0; c_pe = 0; c_max_col = 0;
    a_vs_low = 0; a_max_col = 0; a_max_row = 0; a_ticks = 0; a_last = 0;
    b_pe = 0; b_hs_hi = 0; b_ticks = 0; b_last = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
      check($sformatf("a_scan@%0d", k),
            {row_a, col_a, hsync_a, vsync_a, video_on_a, pix_en_a, frame_tick_a},
            model(k, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 2, 1'b0));
      check($sformatf("b_scan@%0d", k),
            {row_b, col_b, hsync_b, vsync_b, video_on_b, pix_en_b, frame_tick_b},
            model(k, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1, 1'b1));
      check($sformatf("c_scan@%0d", k),
            {row_c, col_c, hsync_c, vsync_c, video_on_c, pix_en_c, frame_tick_c},
            model(k, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0));

      if (k <= 1600) begin
        if (!hsync_c) begin
          c_hs_low++;
          if (c_hs_first == 0) c_hs_first = k;
        end
        if (video_on_c) c_vo++;
        if (pix_en_c) c_pe++;
      end
      if (int'(col_c) > c_max_col) c_max_col = int'(col_c);
      if (k == 1601) begin
        check("c_row_after_line", 32'(row_c), 32'd1);
        check("c_col_after_line", 32'(col_c), 32'd0);
      end

      if (k <= 240 && !vsync_a) a_vs_low++;
      if (int'(col_a) > a_max_col) a_max_col = int'(col_a);
      if (int'(row_a) > a_max_row) a_max_row = int'(row_a);
      if (frame_tick_a) begin
        a_ticks++;
        if (a_last == 0) check("a_first_tick", 32'(k), 32'd241);
        else             check("a_tick_spacing", 32'(k - a_last), 32'd240);
        check("a_tick_pos", {pix_en_a, row_a, col_a}, {13'd0, 1'b1, 19'd0});
        a_last = k;
      end

      if (pix_en_b) b_pe++;
      if (k <= 15 && hsync_b) b_hs_hi++;
      if (k == 16) check("b_row_after_line", 32'(row_b), 32'd1);
      if (frame_tick_b) begin
        b_ticks++;
        if (b_last == 0) check("b_first_tick", 32'(k), 32'd121);
        else             check("b_tick_spacing", 32'(k - b_last), 32'd120);
        b_last = k;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_stats();
    @(negedge clk);
    check_reset("power_on_reset");
    rst = 1'b0;
    k = 0;

    // Into the third frame of the small raster: dut_a is on line 5 (vsync), dut_c mid-line.
    run(640);
    check("a_vsync_before_reset", 32'(vsync_a), 32'd0);
    check("c_col_before_reset", 32'(col_c), 32'd319);

    #2;
    rst = 1'b1;
    #1;
    check_reset("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset($sformatf("reset_hold%0d", i));
    end
    rst = 1'b0;
    k = 0;
    clear_stats();

    run(3300);

    check("c_hsync_low_clks", 32'(c_hs_low), 32'd192);
    check("c_hsync_first_clk", 32'(c_hs_first), 32'd1313);
    check("c_video_on_clks", 32'(c_vo), 32'd1280);
    check("c_pix_en_per_line", 32'(c_pe), 32'd800);
    check("c_max_col", 32'(c_max_col), 32'd639);
    check("a_vsync_low_clks", 32'(a_vs_low), 32'd60);
    check("a_max_col", 32'(a_max_col), 32'd7);
    check("a_max_row", 32'(a_max_row), 32'd3);
    check("a_tick_count", 32'(a_ticks), 32'd13);
    check("b_pix_en_count", 32'(b_pe), 32'd3300);
    check("b_hsync_high_clks", 32'(b_hs_hi), 32'd3);
    check("b_tick_count", 32'(b_ticks), 32'd27);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Produces the raster position (row, col) and the VGA sync signals for the 640x480@60 display.
- Sprite and overlay blocks (the countdown digit renderer, logo and playfield blocks) use row/col to address their ROMs.
- It is the source end of the row/col interface those blocks consume.
- Also emits a pixel-enable strobe and a once-per-frame tick that game timers can use.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (50 MHz clk gives 25 MHz pixel); legal range 1..4
- SYNC_ACTIVE, 0, asserted level of hsync/vsync

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- row  output  9  current line, 0..V_ACTIVE-1
- col  output  10  current pixel, 0..H_ACTIVE-1
- hsync  output  1  horizontal sync, level SYNC_ACTIVE when asserted
- vsync  output  1  vertical sync, level SYNC_ACTIVE when asserted
- video_on  output  1  high while (row, col) is inside the visible area
- pix_en  output  1  one-clk strobe marking the first clk of each new pixel position
- frame_tick  output  1  one-clk strobe when the position wraps to (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Internal counters h_cnt and v_cnt are 10 bits.
- Divider div counts 0..CLK_DIV-1 and wraps. With CLK_DIV=1 the advance condition is true every clk.
- Counter advance: on the edge where div==CLK_DIV-1:
  - h_cnt increments, wrapping H_TOTAL-1 -> 0.
  - On the h wrap, v_cnt increments, wrapping V_TOTAL-1 -> 0.
- Output stage: all outputs are registered and decoded from (h_cnt, v_cnt) every clk. Outputs lag the counters by exactly 1 clk and are mutually aligned. Each position is held for CLK_DIV clks.
- pix_en is high in the single clk in which the outputs first show a new position.
- video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- col = h_cnt while h_cnt < H_ACTIVE, otherwise saturates at H_ACTIVE-1.
- row = v_cnt while v_cnt < V_ACTIVE, otherwise saturates at V_ACTIVE-1.
- Consumers must gate on video_on; row/col never leave the visible range.
- hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751); otherwise it sits at !SYNC_ACTIVE.
- vsync is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), for whole lines.
- frame_tick is high together with pix_en when the outputs show (0,0) reached by a wrap from (H_TOTAL-1, V_TOTAL-1). The first (0,0) after reset does not tick.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV clks = 840000 at the defaults.
- Reset (asynchronous, any time, including mid-line or mid-vsync):
  - div, h_cnt, v_cnt = 0
  - row = 0, col = 0, video_on = 0, pix_en = 0, frame_tick = 0
  - hsync = vsync = !SYNC_ACTIVE
  - The wrap flag is cleared.
- After reset release:
  - First edge: outputs show (0,0), video_on=1, pix_en=1.
  - Then normal scanning; no partial-frame recovery.
- No other inputs, so no simultaneous-event cases beyond the h/v wrap, which is handled in the same edge.

Decomposition:
- Shared package vga_pkg holds:
  - the eight timing constants and the derived H_TOTAL/V_TOTAL,
  - sync start/end constants,
  - widths ROW_W=9 and COL_W=10.
- Sprite blocks use the same package for their screen-window bounds.
- One natural sub-module: vga_axis_counter, instantiated twice (h and v). It provides:
  - an enable input,
  - a wrap output,
  - active/sync window decode, taking active/fp/sync/bp as parameters.

Test Plan:
- Reset mid-frame (assert at h=300, v=200 for 3 clks) -> all outputs at reset values while asserted, asynchronously; first edge after release gives row=0, col=0, video_on=1, pix_en=1, frame_tick=0.
- Defaults, one full line -> pix_en every 2 clks; video_on high for 640 pixels; hsync low for exactly 96 pixels starting at pixel 656; line = 1600 clks.
- Full frame -> vsync low for exactly 2 lines (1600*2 = 3200 clks) starting at line 490; row holds 479 and col holds 639 through blanking.
- Three frames -> frame_tick pulses spaced 840000 clks; each pulse is coincident with pix_en and row=0, col=0.
- CLK_DIV=1, SYNC_ACTIVE=1 -> pix_en constantly high; line = 800 clks; hsync high 656..751; frame = 420000 clks.
- Scoreboard over 2 frames -> row/col sequence matches a reference model; col never exceeds 639 and row never exceeds 479.
